// File: rtl/axil_pkg.sv
// axil_pkg: shared types and constants for the AXI4-Lite command master and
// its helpers.
//   state_t     - master FSM state encoding
//   RESP_*      - AXI4-Lite response codes
//   axil_cmd_t  - captured command (sized for the widest supported address)
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned AXIL_ADDR_MAX = 32;
    localparam int unsigned AXIL_DATA_W   = 32;
    localparam int unsigned AXIL_STRB_W   = AXIL_DATA_W / 8;

    typedef struct packed {
        logic                     write;
        logic [AXIL_ADDR_MAX-1:0] addr;
        logic [AXIL_DATA_W-1:0]   wdata;
        logic [AXIL_STRB_W-1:0]   wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog: saturating cycle counter that flags when a bus phase has run
// for LIMIT cycles. LIMIT = 0 disables it.
// Ports:
//   aclk, aresetn - clock, synchronous active-low reset
//   clr_i         - restart the count (wins over en_i)
//   en_i          - count this cycle
//   expired_o     - the count reaches LIMIT at the coming edge
module axil_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW    = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam bit          Enabled = (LIMIT != 0);
    localparam logic [CntW-1:0] LastCnt = CntW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CntW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // ">=" so a phase entered after a late handshake still times out next cycle.
    assign expired_o = Enabled && en_i && (count_q >= LastCnt);

endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a valid/ready command stream into single AXI4-Lite
// read/write transactions, one outstanding at a time, and returns each result
// on a valid/ready response stream. A watchdog aborts hung bus phases.
// Ports:
//   aclk, aresetn            - clock, synchronous active-low reset
//   cmd_*                    - command stream (write, addr, wdata, wstrb)
//   rsp_*                    - response stream (rdata, resp, timeout)
//   m_aw*/m_w*/m_b*          - AXI4-Lite write channels
//   m_ar*/m_r*               - AXI4-Lite read channels
// All outputs come straight from flops.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    state_t                  state_d, state_q;
    axil_cmd_t               cmd_d, cmd_q;
    logic                    cmd_ready_d, cmd_ready_q;
    logic                    awvalid_d, awvalid_q;
    logic                    wvalid_d, wvalid_q;
    logic                    bready_d, bready_q;
    logic                    arvalid_d, arvalid_q;
    logic                    rready_d, rready_q;
    logic                    rsp_valid_d, rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d, rsp_rdata_q;
    logic [1:0]              rsp_resp_d, rsp_resp_q;
    logic                    rsp_timeout_d, rsp_timeout_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wd_clr, wd_en, wd_expired;
    logic do_timeout;
    logic unused_addr_hi;

    assign aw_hs = awvalid_q && m_awready;
    assign w_hs  = wvalid_q && m_wready;
    assign b_hs  = bready_q && m_bvalid;
    assign ar_hs = arvalid_q && m_arready;
    assign r_hs  = rready_q && m_rvalid;

    assign wd_en = (state_q == WR_AW_W) || (state_q == WR_B) ||
                   (state_q == RD_AR) || (state_q == RD_R);

    axil_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clr        = 1'b0;
        do_timeout    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d.write = cmd_write;
                    cmd_d.addr  = AXIL_ADDR_MAX'(cmd_addr);
                    cmd_d.wdata = cmd_wdata;
                    cmd_d.wstrb = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    wd_clr      = 1'b1;
                    if (cmd_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // Each channel is done if it handshakes now or already did.
                if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    state_d       = RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_AR: begin
                if (ar_hs) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                end
            end
            RD_R: begin
                if (r_hs) begin
                    state_d       = RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_rresp;
                    rsp_rdata_d   = m_rdata;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    do_timeout = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abandoning a dead slave: valids drop without a handshake on purpose.
        if (do_timeout) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // The write flag only steers the FSM; the stored address is wider than the port.
    assign unused_addr_hi = ^{cmd_q.addr, cmd_q.write};

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_awaddr    = cmd_q.addr[ADDR_WIDTH-1:0];
    assign m_awprot    = 3'b000;
    assign m_awvalid   = awvalid_q;
    assign m_wdata     = cmd_q.wdata;
    assign m_wstrb     = cmd_q.wstrb;
    assign m_wvalid    = wvalid_q;
    assign m_bready    = bready_q;
    assign m_araddr    = cmd_q.addr[ADDR_WIDTH-1:0];
    assign m_arprot    = 3'b000;
    assign m_arvalid   = arvalid_q;
    assign m_rready    = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed bench for axil_cmd_master with a small register
// slave (16 words) modelled in tasks. Inputs change on the falling edge and
// outputs are sampled there too.
module tb_axil_cmd_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [5:0]  m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [5:0]  m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    always #5 aclk = ~aclk;

    axil_cmd_master #(
        .ADDR_WIDTH     (6),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .m_awaddr    (m_awaddr),
        .m_awprot    (m_awprot),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_araddr    (m_araddr),
        .m_arprot    (m_arprot),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mem [16];
    logic [5:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    logic        got_to;

    // Presents a command from the current falling edge until it is accepted.
    task automatic issue_cmd(input logic w, input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        bit ok = 1'b0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge aclk);
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
        cmd_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: accepted=%0b want 1", ok);
        end
    endtask

    task automatic serve_write();
        bit found = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_awvalid === 1'b1 && m_wvalid === 1'b1) begin found = 1'b1; break; end
            @(negedge aclk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL aw_w_valid: seen=0 want 1"); end
        cap_addr = m_awaddr; cap_wdata = m_wdata; cap_wstrb = m_wstrb;
        for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) mem[m_awaddr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end
        @(negedge aclk);
        m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_bready === 1'b1) begin found = 1'b1; break; end
            @(negedge aclk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL bready: seen=0 want 1"); end
        @(negedge aclk);
        m_bvalid = 1'b0;
    endtask

    task automatic serve_read();
        bit found = 1'b0;
        m_arready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_arvalid === 1'b1) begin found = 1'b1; break; end
            @(negedge aclk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL arvalid: seen=0 want 1"); end
        cap_addr = m_araddr;
        @(negedge aclk);
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = mem[cap_addr[5:2]]; m_rresp = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_rready === 1'b1) begin found = 1'b1; break; end
            @(negedge aclk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL rready: seen=0 want 1"); end
        @(negedge aclk);
        m_rvalid = 1'b0; m_rdata = '0;
    endtask

    // Waits for a response, records it and consumes it.
    task automatic wait_rsp();
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid === 1'b1) begin found = 1'b1; break; end
            @(negedge aclk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rsp_valid: seen=0 want 1");
            got_rdata = 'x; got_resp = 'x; got_to = 1'bx;
        end else begin
            got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        issue_cmd(1'b1, a, d, s);
        serve_write();
        wait_rsp();
    endtask

    task automatic do_read(input logic [5:0] a);
        issue_cmd(1'b0, a, '0, '0);
        serve_read();
        wait_rsp();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        total++;
        if ({cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'd0)
        begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000", {cmd_ready, rsp_valid, m_awvalid,
                     m_wvalid, m_bready, m_arvalid, m_rready});
        end
        total++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'd0) begin
            bad++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_rdata, rsp_resp, rsp_timeout});
        end
        total++;
        if ({m_awaddr, m_wdata, m_wstrb, m_araddr, m_awprot, m_arprot} !== 54'd0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0",
                     {m_awaddr, m_wdata, m_wstrb, m_araddr, m_awprot, m_arprot});
        end
        aresetn = 1'b1;
        @(negedge aclk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        do_write(6'h00, 32'hDEADBEEF, 4'hF);
        total++;
        if ({cap_addr, cap_wdata, cap_wstrb} !== {6'h00, 32'hDEADBEEF, 4'hF}) begin
            bad++;
            $display("FAIL wr_bus: got %h/%h/%h want 00/deadbeef/f", cap_addr, cap_wdata,
                     cap_wstrb);
        end
        total++;
        if ({got_resp, got_to} !== 3'b000) begin
            bad++; $display("FAIL wr_rsp: got resp=%b to=%b want 00/0", got_resp, got_to);
        end
        do_read(6'h00);
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'hDEADBEEF, 3'b000}) begin
            bad++;
            $display("FAIL rd_rsp: got %h/%b/%b want deadbeef/00/0", got_rdata, got_resp, got_to);
        end
        do_write(6'h24, 32'hCAFEF00D, 4'hF);
        total++;
        if ({cap_addr, got_rdata, got_resp, got_to} !== {6'h24, 32'h0, 3'b000}) begin
            bad++;
            $display("FAIL wr24: got addr=%h rdata=%h resp=%b to=%b want 24/0/00/0", cap_addr,
                     got_rdata, got_resp, got_to);
        end
        do_read(6'h24);
        total++;
        if ({cap_addr, got_rdata} !== {6'h24, 32'hCAFEF00D}) begin
            bad++;
            $display("FAIL rd24: got addr=%h rdata=%h want 24/cafef00d", cap_addr, got_rdata);
        end
    endtask

    task automatic test_partial_strobe();
        do_write(6'h00, 32'h11223344, 4'b0101);
        total++;
        if ({cap_wdata, cap_wstrb} !== {32'h11223344, 4'b0101}) begin
            bad++;
            $display("FAIL strb_bus: got %h/%b want 11223344/0101", cap_wdata, cap_wstrb);
        end
        do_read(6'h00);
        total++;
        if (got_rdata !== 32'hDE22BE44) begin
            bad++; $display("FAIL strb_rd: got %h want de22be44", got_rdata);
        end
    endtask

    task automatic test_skewed();
        m_awready = 1'b0; m_wready = 1'b0;
        issue_cmd(1'b1, 6'h10, 32'hA5A50F0F, 4'hF);
        total++;
        if ({m_awvalid, m_wvalid, m_awaddr, m_wdata} !== {2'b11, 6'h10, 32'hA5A50F0F}) begin
            bad++;
            $display("FAIL skew_entry: got v=%b addr=%h data=%h want 11/10/a5a50f0f",
                     {m_awvalid, m_wvalid}, m_awaddr, m_wdata);
        end
        m_wready = 1'b1;
        @(negedge aclk);
        m_wready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            total++;
            if ({m_awvalid, m_wvalid, m_awaddr} !== {2'b10, 6'h10}) begin
                bad++;
                $display("FAIL skew_aw_hold[%0d]: got v=%b addr=%h want 10/10", k,
                         {m_awvalid, m_wvalid}, m_awaddr);
            end
            if (k == 3) m_awready = 1'b1;
            @(negedge aclk);
        end
        m_awready = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            total++;
            if ({m_awvalid, m_wvalid, m_bready, rsp_valid} !== 4'b0010) begin
                bad++;
                $display("FAIL skew_wr_b[%0d]: got %b want 0010", k,
                         {m_awvalid, m_wvalid, m_bready, rsp_valid});
            end
            if (k == 8) begin m_bvalid = 1'b1; m_bresp = 2'b10; end
            @(negedge aclk);
        end
        m_bvalid = 1'b0; m_bresp = 2'b00;
        total++;
        if (m_bready !== 1'b0) begin
            bad++; $display("FAIL skew_bready_drop: got %b want 0", m_bready);
        end
        wait_rsp();
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'h0, 2'b10, 1'b0}) begin
            bad++;
            $display("FAIL skew_rsp: got %h/%b/%b want 0/10/0", got_rdata, got_resp, got_to);
        end
    endtask

    task automatic test_timeout();
        do_read(6'h00);
        total++;
        if (got_rdata !== 32'hDE22BE44) begin
            bad++; $display("FAIL to_pre_rd: got %h want de22be44", got_rdata);
        end
        m_arready = 1'b0;
        issue_cmd(1'b0, 6'h08, '0, '0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if ({m_arvalid, rsp_valid} !== 2'b10) begin
                bad++;
                $display("FAIL to_ar_hold[%0d]: got %b want 10", k, {m_arvalid, rsp_valid});
            end
            @(negedge aclk);
        end
        total++;
        if ({m_arvalid, m_rready, rsp_valid} !== 3'b001) begin
            bad++;
            $display("FAIL to_expire: got %b want 001", {m_arvalid, m_rready, rsp_valid});
        end
        wait_rsp();
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'h0, 2'b10, 1'b1}) begin
            bad++;
            $display("FAIL to_rsp: got %h/%b/%b want 0/10/1", got_rdata, got_resp, got_to);
        end
        do_read(6'h24);
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'hCAFEF00D, 3'b000}) begin
            bad++;
            $display("FAIL to_next: got %h/%b/%b want cafef00d/00/0", got_rdata, got_resp, got_to);
        end
    endtask

    // AR handshake on the last allowed cycle, then DECERR read data.
    task automatic test_timeout_boundary();
        m_arready = 1'b0;
        issue_cmd(1'b0, 6'h0C, '0, '0);
        for (int k = 0; k < 15; k++) @(negedge aclk);
        m_arready = 1'b1;
        @(negedge aclk);
        m_arready = 1'b0;
        total++;
        if ({m_arvalid, m_rready, rsp_valid} !== 3'b010) begin
            bad++;
            $display("FAIL edge_ar_wins: got %b want 010", {m_arvalid, m_rready, rsp_valid});
        end
        m_rvalid = 1'b1; m_rdata = 32'h5A5A5A5A; m_rresp = 2'b11;
        @(negedge aclk);
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        wait_rsp();
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'h5A5A5A5A, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL edge_rsp: got %h/%b/%b want 5a5a5a5a/11/0", got_rdata, got_resp,
                     got_to);
        end
    endtask

    task automatic test_backpressure_reset();
        issue_cmd(1'b0, 6'h24, '0, '0);
        serve_read();
        // A new command offered while the response waits must be ignored.
        cmd_write = 1'b1; cmd_addr = 6'h3C; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            total++;
            if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, m_awvalid} !==
                {1'b1, 32'hCAFEF00D, 2'b00, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h r=%b t=%b cr=%b aw=%b want 1/cafef00d/00/0/0/0",
                         k, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, m_awvalid);
            end
            @(negedge aclk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, m_awvalid, m_arvalid} !== 4'b0100) begin
            bad++;
            $display("FAIL bp_release: got %b want 0100",
                     {rsp_valid, cmd_ready, m_awvalid, m_arvalid});
        end
        m_awready = 1'b1; m_wready = 1'b1;
        issue_cmd(1'b1, 6'h30, 32'h12345678, 4'hF);
        @(negedge aclk);
        m_awready = 1'b0; m_wready = 1'b0;
        total++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin
            bad++;
            $display("FAIL rst_in_wr_b: got %b want 001", {m_awvalid, m_wvalid, m_bready});
        end
        aresetn = 1'b0;
        @(negedge aclk);
        total++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, cmd_ready} !== 7'd0)
        begin
            bad++;
            $display("FAIL rst_abort: got %b want 0000000", {m_awvalid, m_wvalid, m_bready,
                     m_arvalid, m_rready, rsp_valid, cmd_ready});
        end
        aresetn = 1'b1;
        @(negedge aclk);
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_idle: got %b want 10", {cmd_ready, rsp_valid});
        end
        do_read(6'h00);
        total++;
        if ({got_rdata, got_resp, got_to} !== {32'hDE22BE44, 3'b000}) begin
            bad++;
            $display("FAIL rst_next: got %h/%b/%b want de22be44/00/0", got_rdata, got_resp, got_to);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_skewed();
        test_timeout();
        test_timeout_boundary();
        test_backpressure_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions, and returns each result on a valid/ready response stream. It is the master-side counterpart to the team's AXI-Lite register slaves, such as the ADXL345 control block. It is used by on-chip sequencers and testbenches to program and poll those register files without a CPU. One transaction is outstanding at a time, and a watchdog guards against hung slaves.

Parameters:
- ADDR_WIDTH, 6, byte address width of the AXI4-Lite address channels.
- DATA_WIDTH, 32, data width; only 32 is supported, and the strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, bus-phase watchdog limit in aclk cycles; 0 disables the watchdog.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code, or 2'b10 on timeout.
- rsp_timeout  out  1  watchdog expired for this transaction.
- m_awaddr/m_awprot/m_awvalid  out  ADDR_WIDTH/3/1  AW channel.
- m_awready  in  1  AW channel.
- m_wdata/m_wstrb/m_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  W channel.
- m_wready  in  1  W channel.
- m_bresp/m_bvalid  in  2/1  B channel.
- m_bready  out  1  B channel.
- m_araddr/m_arprot/m_arvalid  out  ADDR_WIDTH/3/1  AR channel.
- m_arready  in  1  AR channel.
- m_rdata/m_rresp/m_rvalid  in  DATA_WIDTH/2/1  R channel.
- m_rready  out  1  R channel.

Behaviour:
- Reset values (aresetn low at a clock edge): state IDLE; all m_*valid, m_bready, m_rready, and rsp_valid are 0; cmd_ready is 0 during reset; all data, address and response registers are 0; the watchdog counter is 0.
- All outputs are registered. m_awprot and m_arprot are constant 3'b000.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, capture addr, wdata, wstrb and write.
  - Write commands go to WR_AW_W; read commands go to RD_AR.
  - The first AXI valid rises on the cycle after acceptance (latency 1).
- WR_AW_W:
  - m_awvalid and m_wvalid rise together on entry.
  - Each valid drops on the cycle after its own handshake.
  - AW and W may handshake in the same cycle or in different cycles, in either order.
  - Address and data stay stable while the corresponding valid is high.
  - When both handshakes have completed, go to WR_B.
- WR_B:
  - m_bready = 1.
  - On m_bvalid & m_bready, latch rsp_resp = m_bresp and rsp_rdata = 0, then go to RSP.
  - m_bready drops on the next cycle.
- RD_AR:
  - m_arvalid = 1 until the m_arready handshake, then go to RD_R.
- RD_R:
  - m_rready = 1.
  - On m_rvalid & m_rready, latch m_rdata and m_rresp, then go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable.
  - On rsp_ready, clear rsp_valid and return to IDLE.
  - cmd_ready stays 0 until IDLE, so a back-to-back command is accepted at the earliest 1 cycle after the response handshake.
- Watchdog:
  - The counter clears on command acceptance and increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0):
    - drop all m_*valid, m_bready and m_rready;
    - set rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0;
    - go to RSP.
  - This deliberately violates the AXI valid-hold rule to recover from a dead slave.
  - A handshake that completes in the same cycle the counter reaches the limit wins: the transaction completes normally and no timeout is reported.
- SLVERR and DECERR from the slave are passed through unchanged with rsp_timeout = 0.
- Reset mid-transaction: abort immediately; all valids low on the next edge; no response is produced.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Package axil_pkg:
  - typedef enum state_t {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP};
  - localparams RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - typedef struct axil_cmd_t {write, addr, wdata, wstrb}.
- Sub-module axil_watchdog: counter with clear, enable, limit and expired outputs. It is reused by future bus masters.
- Everything else stays in one module.

Test Plan:
- Write, then read back: write addr 0x00, wdata 0xDEADBEEF, wstrb 4'hF into the team's AXI-Lite slave, then read addr 0x00 → write rsp_resp=00 and rsp_timeout=0; read rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Partial strobe: write 0x11223344 with wstrb 4'b0101 over prior 0xDEADBEEF, then read back → rsp_rdata=0xDE22BE44.
- Skewed handshakes: BFM slave asserts m_wready 3 cycles before m_awready, then asserts m_bvalid 5 cycles later with bresp 2'b10 → m_wvalid drops first, m_awaddr stays stable throughout, and the response reports rsp_resp=10, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16 and the slave never asserts m_arready → m_arvalid drops at cycle 16; rsp_valid=1 with rsp_resp=10, rsp_timeout=1, rsp_rdata=0; the next command is accepted normally.
- Response backpressure and reset: hold rsp_ready=0 for 10 cycles → rsp_* stable and cmd_ready=0 throughout; then assert aresetn=0 during a WR_B state → all valids and readies are 0 after the next edge, and after reset the block is in IDLE with cmd_ready=1.
